// File: rtl/pyr_dense_optical_flow_accel_interp_acc_pkg.sv
// Shared widths and round/saturate bound helper for the pyramid dense optical-flow stages.
package pyr_dense_of_pkg;

  localparam int unsigned DEFAULT_PROD_WIDTH = 34;
  localparam int unsigned DEFAULT_TAPS       = 4;
  localparam int unsigned DEFAULT_FRAC_BITS  = 16;
  localparam int unsigned DEFAULT_ACC_WIDTH  = 36;
  localparam int unsigned DEFAULT_OUT_WIDTH  = 17;

  typedef struct packed {
    logic signed [63:0] round_const;
    logic signed [63:0] max_val;
    logic signed [63:0] min_val;
  } rs_bounds_t;

  function automatic rs_bounds_t rs_bounds(input int unsigned out_width,
                                           input int unsigned frac_bits);
    rs_bounds_t b;
    b.round_const = 64'sd1 <<< (frac_bits - 1);
    b.max_val     = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    b.min_val     = -(64'sd1 <<< (out_width - 1));
    return b;
  endfunction

endpackage

// File: rtl/pyr_dense_optical_flow_accel_interp_acc_if.sv
// Product-in / sample-out valid-ready bus of the interpolation accumulator.
interface pyr_dense_optical_flow_accel_interp_acc_if #(
  parameter int unsigned PROD_WIDTH = pyr_dense_of_pkg::DEFAULT_PROD_WIDTH,
  parameter int unsigned OUT_WIDTH  = pyr_dense_of_pkg::DEFAULT_OUT_WIDTH
);
  logic                  in_valid;
  logic                  in_ready;
  logic [PROD_WIDTH-1:0] in_prod;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  out_sat;

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/pyr_dense_optical_flow_accel_round_sat.sv
// Round-half-up, arithmetic shift by FRAC_BITS and clamp to a signed OUT_WIDTH sample.
module pyr_dense_optical_flow_accel_round_sat
  import pyr_dense_of_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = DEFAULT_ACC_WIDTH,
  parameter int unsigned FRAC_BITS = DEFAULT_FRAC_BITS,
  parameter int unsigned OUT_WIDTH = DEFAULT_OUT_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0] sum,
  output logic        [OUT_WIDTH-1:0] value,
  output logic                        sat
);

  localparam rs_bounds_t BOUNDS = rs_bounds(OUT_WIDTH, FRAC_BITS);
  localparam logic signed [63:0] SAT_MAX = BOUNDS.max_val;
  localparam logic signed [63:0] SAT_MIN = BOUNDS.min_val;
  localparam logic signed [63:0] RND_64  = BOUNDS.round_const;
  localparam logic signed [ACC_WIDTH:0] RND     = RND_64[ACC_WIDTH:0];
  localparam logic [OUT_WIDTH-1:0]      MAX_OUT = SAT_MAX[OUT_WIDTH-1:0];
  localparam logic [OUT_WIDTH-1:0]      MIN_OUT = SAT_MIN[OUT_WIDTH-1:0];

  logic signed [ACC_WIDTH:0] biased;
  logic signed [ACC_WIDTH:0] shifted;
  logic signed [63:0]        r_ext;

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  always_comb begin
    biased  = {sum[ACC_WIDTH-1], sum} + RND;
    shifted = biased >>> FRAC_BITS;
    r_ext   = {{(63 - ACC_WIDTH){shifted[ACC_WIDTH]}}, shifted};
    value   = shifted[OUT_WIDTH-1:0];
    sat     = 1'b0;
    if (r_ext > SAT_MAX) begin
      value = MAX_OUT;
      sat   = 1'b1;
    end else if (r_ext < SAT_MIN) begin
      value = MIN_OUT;
      sat   = 1'b1;
    end
  end

endmodule

// File: rtl/pyr_dense_optical_flow_accel_interp_acc.sv
// Accumulates TAPS signed products per group and emits a rounded, saturated sample.
// Optional saturation counter port sat_count: PYR_DENSE_OF_INTERP_SAT_CNT_EN.
module pyr_dense_optical_flow_accel_interp_acc
  import pyr_dense_of_pkg::*;
#(
  parameter int unsigned PROD_WIDTH = DEFAULT_PROD_WIDTH,
  parameter int unsigned TAPS       = DEFAULT_TAPS,
  parameter int unsigned FRAC_BITS  = DEFAULT_FRAC_BITS,
  parameter int unsigned ACC_WIDTH  = DEFAULT_ACC_WIDTH,
  parameter int unsigned OUT_WIDTH  = DEFAULT_OUT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
`ifdef PYR_DENSE_OF_INTERP_SAT_CNT_EN
  output logic [15:0] sat_count,
`endif
  pyr_dense_optical_flow_accel_interp_acc_if.slave bus
);

  localparam int unsigned     CNT_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

  logic [CNT_W-1:0]            tap_cnt;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic                        last_tap;
  logic                        hold;
  logic                        in_fire;
  logic                        out_fire;
  logic [OUT_WIDTH-1:0]        rs_value;
  logic                        rs_sat;
  logic                        out_valid_q;
  logic [OUT_WIDTH-1:0]        out_data_q;
  logic                        out_sat_q;

  assign prod_ext = {{(ACC_WIDTH - PROD_WIDTH){bus.in_prod[PROD_WIDTH-1]}}, bus.in_prod};
  assign sum      = acc + prod_ext;
  assign last_tap = (tap_cnt == LAST_TAP);
  assign hold     = out_valid_q & ~bus.out_ready;

  // Only the closing tap of a group needs the output register free.
  assign bus.in_ready = ~(hold & last_tap);
  assign in_fire      = ce & bus.in_valid & bus.in_ready;
  assign out_fire     = ce & out_valid_q & bus.out_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  pyr_dense_optical_flow_accel_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_round_sat (
    .sum   (sum),
    .value (rs_value),
    .sat   (rs_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tap_cnt     <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (ce) begin
      if (in_fire) begin
        tap_cnt <= last_tap ? '0 : tap_cnt + CNT_W'(1);
        acc     <= (tap_cnt == '0) ? prod_ext : sum;
      end
      if (in_fire && last_tap) begin
        out_data_q  <= rs_value;
        out_sat_q   <= rs_sat;
        out_valid_q <= 1'b1;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef PYR_DENSE_OF_INTERP_SAT_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_count <= '0;
    end else if (in_fire && last_tap && rs_sat && (sat_count != '1)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pyr_dense_optical_flow_accel_interp_acc.sv
// Directed and scoreboarded checks for the interpolation accumulator.
module tb_pyr_dense_optical_flow_accel_interp_acc;

  logic clk = 1'b0;
  logic reset;
  logic ce;
`ifdef PYR_DENSE_OF_INTERP_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pyr_dense_optical_flow_accel_interp_acc_if #(
    .PROD_WIDTH (34),
    .OUT_WIDTH  (17)
  ) bus ();

  pyr_dense_optical_flow_accel_interp_acc #(
    .PROD_WIDTH (34),
    .TAPS       (4),
    .FRAC_BITS  (16),
    .ACC_WIDTH  (36),
    .OUT_WIDTH  (17)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
`ifdef PYR_DENSE_OF_INTERP_SAT_CNT_EN
    .sat_count (sat_count),
`endif
    .bus       (bus.slave)
  );

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tap(input longint v);
    bus.in_valid = 1'b1;
    bus.in_prod  = v[33:0];
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_group(input string tag, input longint a, input longint b,
                            input longint c, input longint d,
                            input longint exp_data, input logic exp_sat);
    send_tap(a);
    send_tap(b);
    send_tap(c);
    send_tap(d);
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_data"}, $signed(bus.out_data), exp_data);
    check({tag, "_sat"}, bus.out_sat, exp_sat);
  endtask

  task automatic ref_model(input longint s, output longint d, output longint sat);
    longint r;
    r = (s + 32768) >>> 16;
    sat = 0;
    d = r;
    if (r > 65535) begin
      d = 65535;
      sat = 1;
    end else if (r < -65536) begin
      d = -65536;
      sat = 1;
    end
  endtask

  function automatic longint rand_prod();
    longint base;
    base = longint'($urandom_range(0, (1 << 22) - 1)) - longint'(1 << 21);
    return base <<< $urandom_range(0, 12);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    longint q_data[$];
    longint q_sat[$];
    longint pend, acc_m, exp_d, exp_s;
    int     taps_m, sent, got;
    logic   in_f, out_f;

    reset = 1'b1;
    ce = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_prod = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("reset_valid", bus.out_valid, 0);
    check("reset_data", $signed(bus.out_data), 0);
    check("reset_sat", bus.out_sat, 0);
    check("reset_in_ready", bus.in_ready, 1);
    reset = 1'b0;

    // basic group
    send_group("basic", 65536, 65536, 65536, 65536, 4, 1'b0);
    tick();
    check("basic_consumed", bus.out_valid, 0);

    // rounding boundaries
    send_group("rnd_half", 0, 0, 0, 32768, 1, 1'b0);
    send_group("rnd_neg_half", 0, 0, 0, -32768, 0, 1'b0);
    send_group("rnd_below", 0, 0, 0, -32769, -1, 1'b0);

    // saturation
    send_group("sat_pos", (64'sd1 <<< 33) - 1, (64'sd1 <<< 33) - 1,
               (64'sd1 <<< 33) - 1, (64'sd1 <<< 33) - 1, 65535, 1'b1);
    send_group("sat_neg", -(64'sd1 <<< 33), -(64'sd1 <<< 33),
               -(64'sd1 <<< 33), -(64'sd1 <<< 33), -65536, 1'b1);
`ifdef PYR_DENSE_OF_INTERP_SAT_CNT_EN
    check("sat_count", sat_count, 2);
`endif

    // backpressure
    tick();
    check("bp_idle", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_prod  = (i < 4) ? 34'd65536 : 34'd131072;
      #1;
      check($sformatf("bp_in_ready_%0d", i), bus.in_ready, (i == 7) ? 0 : 1);
      if (i >= 4) check($sformatf("bp_hold_data_%0d", i), $signed(bus.out_data), 4);
      if (i < 7) tick();
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_stall_valid", bus.out_valid, 1);
      check("bp_stall_data", $signed(bus.out_data), 4);
      check("bp_stall_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_second_valid", bus.out_valid, 1);
    check("bp_second_data", $signed(bus.out_data), 8);
    tick();
    check("bp_drained", bus.out_valid, 0);

    // ce freeze mid-group
    send_tap(65536);
    send_tap(65536);
    ce = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_prod = 34'd1073741824;
    for (int k = 0; k < 5; k++) tick();
    check("ce_frozen_valid", bus.out_valid, 0);
    ce = 1'b1;
    bus.in_valid = 1'b0;
    send_tap(65536);
    send_tap(65536);
    check("ce_resume_valid", bus.out_valid, 1);
    check("ce_resume_data", $signed(bus.out_data), 4);
    ce = 1'b0;
    tick();
    check("ce_hold_out_valid", bus.out_valid, 1);
    ce = 1'b1;
    tick();
    check("ce_out_consumed", bus.out_valid, 0);

    // reset mid-group discards the partial sum
    send_tap(1073741824);
    send_tap(1073741824);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_valid", bus.out_valid, 0);
`ifdef PYR_DENSE_OF_INTERP_SAT_CNT_EN
    check("rst_sat_count", sat_count, 0);
`endif
    send_group("rst_mid", 65536, 65536, 65536, 65536, 4, 1'b0);
    tick();

    // streaming against a reference model
    pend = rand_prod();
    acc_m = 0;
    taps_m = 0;
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 600 && got < 10; cyc++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 40) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_prod  = pend[33:0];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      in_f  = bus.in_valid & bus.in_ready;
      out_f = bus.out_valid & bus.out_ready;
      if (out_f) begin
        if (q_data.size() == 0) begin
          check("stream_extra_result", 1, 0);
        end else begin
          exp_d = q_data.pop_front();
          exp_s = q_sat.pop_front();
          check($sformatf("stream_data_%0d", got), $signed(bus.out_data), exp_d);
          check($sformatf("stream_sat_%0d", got), bus.out_sat, exp_s);
        end
        got++;
      end
      tick();
      if (in_f) begin
        acc_m = (taps_m == 0) ? pend : acc_m + pend;
        taps_m++;
        sent++;
        if (taps_m == 4) begin
          ref_model(acc_m, exp_d, exp_s);
          q_data.push_back(exp_d);
          q_sat.push_back(exp_s);
          taps_m = 0;
        end
        pend = rand_prod();
      end
    end
    bus.in_valid = 1'b0;
    check("stream_count", got, 10);
    check("stream_taps", sent, 40);
    tick();
    check("stream_drained", bus.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
